// File: rtl/mem_port_scheduler.sv
// Round-robin scheduler sharing one main-memory port among several cache controllers.
// Define SCHED_TIMEOUT_EN to build the WAIT-state watchdog that ends hung transactions with an error.
module mem_port_scheduler #(
  parameter int Num_caches     = 2,
  parameter int Address_bits   = 64,
  parameter int Data_bits      = 512,
  parameter int Timeout_cycles = 1023
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [Num_caches-1:0]              p_req,
  input  logic [Num_caches-1:0]              p_we,
  input  logic [Num_caches*Address_bits-1:0] p_addr,
  input  logic [Num_caches*Data_bits-1:0]    p_write_data,
  output logic [Num_caches-1:0]              p_done,
  output logic [Num_caches-1:0]              p_error,
  output logic [Data_bits-1:0]               p_read_data,
  output logic [Address_bits-1:0]            m_addr,
  output logic [Data_bits-1:0]               m_write_data,
  output logic                               m_read_en,
  output logic                               m_write_en,
  input  logic [Data_bits-1:0]               m_read_data,
  input  logic                               m_done,
  output logic                               busy,
  output logic [$clog2(Num_caches)-1:0]      serving,
  output logic                               timeout_err
);

  localparam int SW = $clog2(Num_caches);

  if (Num_caches < 2 || Num_caches > 16) begin : g_bad_num_caches
    $error("mem_port_scheduler: Num_caches must be in 2..16");
  end
  if (Timeout_cycles < 1) begin : g_bad_timeout
    $error("mem_port_scheduler: Timeout_cycles must be at least 1");
  end

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e                  state_q, state_d;
  logic [SW-1:0]           ptr_q, ptr_d;
  logic [SW-1:0]           serving_q, serving_d;
  logic [Address_bits-1:0] addr_q, addr_d;
  logic [Data_bits-1:0]    wdata_q, wdata_d;
  logic [Data_bits-1:0]    rdata_q, rdata_d;
  logic                    we_q, we_d;

  logic                    found;
  logic [SW-1:0]           winner;
  logic [SW-1:0]           cand;
  logic                    timeout_hit;
  logic [Num_caches-1:0]   serve_onehot;

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    cand   = '0;
    for (int k = 1; k <= Num_caches; k++) begin
      cand = SW'((int'(ptr_q) + k) % Num_caches);
      if (!found && p_req[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    serving_d = serving_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    we_d      = we_q;
    rdata_d   = rdata_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          ptr_d     = winner;
          serving_d = winner;
          addr_d    = p_addr[int'(winner)*Address_bits +: Address_bits];
          wdata_d   = p_write_data[int'(winner)*Data_bits +: Data_bits];
          we_d      = p_we[winner];
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        // A same-cycle completion takes priority over the watchdog.
        if (m_done) begin
          rdata_d = we_q ? '0 : m_read_data;
          state_d = RESP;
        end else if (timeout_hit) begin
          rdata_d = '0;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      ptr_q     <= SW'(Num_caches - 1);
      serving_q <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      we_q      <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      serving_q <= serving_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      we_q      <= we_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam int TW = $clog2(Timeout_cycles + 1);

  logic [TW-1:0] wdog_q, wdog_d;
  logic          err_q, err_d;
  logic          timeout_err_q, timeout_err_d;

  assign timeout_hit = (wdog_q == TW'(Timeout_cycles));

  always_comb begin
    wdog_d        = wdog_q;
    err_d         = err_q;
    timeout_err_d = timeout_err_q;
    case (state_q)
      IDLE, ISSUE: begin
        wdog_d = '0;
        err_d  = 1'b0;
      end
      WAIT: begin
        if (!m_done) begin
          if (timeout_hit) begin
            err_d         = 1'b1;
            timeout_err_d = 1'b1;
          end else begin
            wdog_d = wdog_q + TW'(1);
          end
        end
      end
      default: begin
        wdog_d = wdog_q;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q        <= '0;
      err_q         <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      wdog_q        <= wdog_d;
      err_q         <= err_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign p_error     = (state_q == RESP && err_q) ? serve_onehot : '0;
  assign timeout_err = timeout_err_q;
`else
  assign timeout_hit = 1'b0;
  assign p_error     = '0;
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    serve_onehot            = '0;
    serve_onehot[serving_q] = 1'b1;
  end

  assign p_done       = (state_q == RESP) ? serve_onehot : '0;
  assign p_read_data  = (state_q == RESP) ? rdata_q : '0;
  assign m_read_en    = (state_q == ISSUE) && !we_q;
  assign m_write_en   = (state_q == ISSUE) && we_q;
  assign m_addr       = addr_q;
  assign m_write_data = wdata_q;
  assign busy         = (state_q != IDLE);
  assign serving      = serving_q;

endmodule

// File: tb/tb_mem_port_scheduler.sv
// Directed testbench for mem_port_scheduler with immediate-assertion checks.
// Covers reset, read/write paths, round-robin rotation, mid-transaction reset and the watchdog.
module tb_mem_port_scheduler;

  localparam int N  = 2;
  localparam int AW = 64;
  localparam int DW = 512;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [N-1:0]      p_req;
  logic [N-1:0]      p_we;
  logic [N*AW-1:0]   p_addr;
  logic [N*DW-1:0]   p_write_data;
  logic [N-1:0]      p_done;
  logic [N-1:0]      p_error;
  logic [DW-1:0]     p_read_data;
  logic [AW-1:0]     m_addr;
  logic [DW-1:0]     m_write_data;
  logic              m_read_en;
  logic              m_write_en;
  logic [DW-1:0]     m_read_data;
  logic              m_done;
  logic              busy;
  logic [0:0]        serving;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  mem_port_scheduler #(
    .Num_caches    (N),
    .Address_bits  (AW),
    .Data_bits     (DW),
    .Timeout_cycles(4)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .p_req       (p_req),
    .p_we        (p_we),
    .p_addr      (p_addr),
    .p_write_data(p_write_data),
    .p_done      (p_done),
    .p_error     (p_error),
    .p_read_data (p_read_data),
    .m_addr      (m_addr),
    .m_write_data(m_write_data),
    .m_read_en   (m_read_en),
    .m_write_en  (m_write_en),
    .m_read_data (m_read_data),
    .m_done      (m_done),
    .busy        (busy),
    .serving     (serving),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed,
                             input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [N-1:0] req, input logic [N-1:0] we,
                               input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                               input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    p_req        = req;
    p_we         = we;
    p_addr       = {a1, a0};
    p_write_data = {d1, d0};
  endtask

  task automatic waitStrobe();
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      if (m_read_en || m_write_en) seen = 1'b1;
    end
    checkOutput("strobe_seen", seen, 1'b1);
  endtask

  // Starts with request inputs applied; ends at the negedge inside the RESP cycle.
  task automatic runTxn(input int idx, input logic we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wd, input int wait_cycles,
                        input logic [DW-1:0] mem_rd, input logic [DW-1:0] exp_rd);
    logic [N-1:0] exp_done;
    exp_done      = '0;
    exp_done[idx] = 1'b1;
    waitStrobe();
    checkOutput("m_read_en", m_read_en, !we);
    checkOutput("m_write_en", m_write_en, we);
    checkOutput("m_addr", m_addr, addr);
    checkOutput("m_write_data", m_write_data, wd);
    checkOutput("serving_issue", serving, idx);
    checkOutput("busy_issue", busy, 1'b1);
    checkOutput("no_done_issue", p_done, '0);
    for (int i = 1; i <= wait_cycles; i++) begin
      @(negedge clk);
      checkOutput("wait_no_strobe", {m_read_en, m_write_en}, 2'b00);
      checkOutput("wait_no_done", p_done, '0);
      if (i == wait_cycles) begin
        m_done      = 1'b1;
        m_read_data = mem_rd;
      end
    end
    @(negedge clk);
    m_done      = 1'b0;
    m_read_data = {16{32'hDEADBEEF}};
    checkOutput("p_done", p_done, exp_done);
    checkOutput("p_error", p_error, '0);
    checkOutput("p_read_data", p_read_data, exp_rd);
    checkOutput("serving_resp", serving, idx);
    checkOutput("m_addr_hold", m_addr, addr);
    checkOutput("busy_resp", busy, 1'b1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=hang expected=finish");
    $fatal(1, "[TB] simulation did not finish");
  end

  initial begin
    logic [DW-1:0] pat_a5;
    logic [DW-1:0] pat_r1;
    logic [DW-1:0] pat_r2;
    logic [DW-1:0] pat_r3;
    logic [DW-1:0] wd0;
    logic          got_done;
    int            k;

    pat_a5 = {64{8'hA5}};
    pat_r1 = {16{32'h11112222}};
    pat_r2 = {16{32'h33334444}};
    pat_r3 = {16{32'h55556666}};
    wd0    = {8{64'h0000_0000_0000_0055}};

    rst_n       = 1'b0;
    m_done      = 1'b0;
    m_read_data = '0;
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checkOutput("rst_p_done", p_done, '0);
    checkOutput("rst_p_error", p_error, '0);
    checkOutput("rst_p_read_data", p_read_data, '0);
    checkOutput("rst_m_addr", m_addr, '0);
    checkOutput("rst_m_write_data", m_write_data, '0);
    checkOutput("rst_strobes", {m_read_en, m_write_en}, 2'b00);
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_serving", serving, 1'b0);
    checkOutput("rst_timeout_err", timeout_err, 1'b0);

    // Requester 0 read of 0x40, memory answers two cycles after the strobe
    rst_n = 1'b1;
    applyStimulus(2'b01, 2'b00, 64'h40, '0, wd0, '0);
    runTxn(0, 1'b0, 64'h40, wd0, 2, pat_a5, pat_a5);

    // Requester 1 write of 0x80 / 0x1234; read data returns zero
    applyStimulus(2'b10, 2'b10, '0, 64'h80, '0, 512'h1234);
    runTxn(1, 1'b1, 64'h80, 512'h1234, 1, pat_r1, '0);

    // Both requesters continuously: grants rotate 0,1,0,1,0,1
    applyStimulus(2'b11, 2'b10, 64'h100, 64'h200, wd0, 512'hBEEF);
    runTxn(0, 1'b0, 64'h100, wd0, 1, pat_r1, pat_r1);
    runTxn(1, 1'b1, 64'h200, 512'hBEEF, 2, pat_r2, '0);
    runTxn(0, 1'b0, 64'h100, wd0, 3, pat_r2, pat_r2);
    runTxn(1, 1'b1, 64'h200, 512'hBEEF, 1, pat_r3, '0);
    runTxn(0, 1'b0, 64'h100, wd0, 2, pat_r3, pat_r3);
    runTxn(1, 1'b1, 64'h200, 512'hBEEF, 1, pat_r1, '0);

    // Reset during WAIT aborts and restores requester 0 priority
    applyStimulus(2'b01, 2'b00, 64'h300, '0, wd0, '0);
    waitStrobe();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_strobes", {m_read_en, m_write_en}, 2'b00);
    checkOutput("abort_p_done", p_done, '0);
    checkOutput("abort_m_addr", m_addr, '0);
    checkOutput("abort_m_write_data", m_write_data, '0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(2'b11, 2'b10, 64'h300, 64'h380, wd0, 512'h77);
    runTxn(0, 1'b0, 64'h300, wd0, 1, pat_r2, pat_r2);

`ifdef SCHED_TIMEOUT_EN
    // Memory never completes: watchdog ends the transaction with an error
    applyStimulus(2'b01, 2'b00, 64'h400, '0, wd0, '0);
    waitStrobe();
    got_done = 1'b0;
    k = 0;
    while (!got_done && k < 20) begin
      @(negedge clk);
      k++;
      if (p_done != '0) got_done = 1'b1;
    end
    applyStimulus(2'b00, 2'b00, '0, '0, '0, '0);
    checkOutput("to_done_seen", got_done, 1'b1);
    checkOutput("to_not_early", (k >= 5), 1'b1);
    checkOutput("to_p_done", p_done, 2'b01);
    checkOutput("to_p_error", p_error, 2'b01);
    checkOutput("to_p_read_data", p_read_data, '0);
    checkOutput("to_flag_resp", timeout_err, 1'b1);
    @(negedge clk);
    checkOutput("to_flag_sticky", timeout_err, 1'b1);
    checkOutput("to_error_cleared", p_error, '0);

    // Completion just before the limit gives a normal response
    applyStimulus(2'b01, 2'b00, 64'h440, '0, wd0, '0);
    runTxn(0, 1'b0, 64'h440, wd0, 4, pat_r3, pat_r3);
    checkOutput("to_flag_still", timeout_err, 1'b1);

    // Completion in the very cycle the limit is reached wins over the watchdog
    applyStimulus(2'b01, 2'b00, 64'h480, '0, wd0, '0);
    runTxn(0, 1'b0, 64'h480, wd0, 5, pat_a5, pat_a5);
`else
    // Without the watchdog WAIT lasts until memory completes
    applyStimulus(2'b01, 2'b00, 64'h400, '0, wd0, '0);
    got_done = 1'b0;
    k = 0;
    runTxn(0, 1'b0, 64'h400, wd0, 12, pat_r3, pat_r3);
    checkOutput("no_wdog_flag", timeout_err, 1'b0);
    checkOutput("no_wdog_got_done", got_done, 1'b0);
    checkOutput("no_wdog_k", k, 0);
`endif

    @(negedge clk);
    checkOutput("final_idle_busy", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
